// File: rtl/dco_tune_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dco_tune_ctrl
// Description : Closed-loop DCO acquisition controller. Measures DCO cycles
//               per reference window from a Gray-coded phase counter and
//               binary-searches the coarse (CTW) then fine (FTW) tuning words
//               until the measured count matches the target word.
//               Optional macro DCO_TUNE_TRACK_EN: in LOCK, each decide cycle
//               nudges FTW by one LSB toward the target.
// Revision    : 1.0 - initial release
// ============================================================================
module dco_tune_ctrl #(
    parameter int CTW_BITS = 4,
    parameter int PH_W     = 8,
    parameter int MEAS_W   = 16,
    parameter int SETTLE   = 8,
    parameter int WIN      = 64,
    parameter int LOCK_TOL = 2
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic              i_start,
    input  logic [MEAS_W-1:0] i_fcw,
    input  logic [PH_W-1:0]   i_dco_phase_gray,
    output logic [7:0]        o_ctw,
    output logic [7:0]        o_ftw,
    output logic              o_dco_en,
    output logic              o_busy,
    output logic              o_lock,
    output logic              o_fail,
    output logic [MEAS_W-1:0] o_meas,
    output logic              o_meas_valid
);

    localparam int STEP_LEN = SETTLE + WIN + 1;
    localparam int CNT_W    = $clog2(STEP_LEN);

    localparam logic [CNT_W-1:0]  c_WIN_START = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0]  c_DECIDE    = CNT_W'(SETTLE + WIN);
    localparam logic [7:0]        c_CTW_INIT  = 8'(1) << (CTW_BITS - 1);
    localparam logic [2:0]        c_CTW_TOP   = 3'(CTW_BITS - 1);
    localparam logic [MEAS_W-1:0] c_TOL       = MEAS_W'(LOCK_TOL);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_COARSE = 3'd1;
    localparam logic [2:0] c_ST_FINE   = 3'd2;
    localparam logic [2:0] c_ST_VERIFY = 3'd3;
    localparam logic [2:0] c_ST_LOCK   = 3'd4;
    localparam logic [2:0] c_ST_FAIL   = 3'd5;

    logic [PH_W-1:0]   r_ph_s1;
    logic [PH_W-1:0]   r_ph_s2;
    logic [PH_W-1:0]   r_ph_bin_prev;
    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit;
    logic [MEAS_W-1:0] r_acc;
    logic [MEAS_W-1:0] r_meas;
    logic              r_meas_valid;
    logic [7:0]        r_ctw;
    logic [7:0]        r_ftw;
    logic              r_dco_en;
    logic              r_busy;
    logic              r_lock;
    logic              r_fail;

    logic [PH_W-1:0]   w_ph_bin;
    logic [PH_W-1:0]   w_delta;
    logic [MEAS_W:0]   w_acc_sum;
    logic [MEAS_W-1:0] w_acc_next;
    logic              w_measuring;
    logic              w_in_win;
    logic              w_decide;
    logic [MEAS_W-1:0] w_diff;
    logic              w_in_tol;
    logic [7:0]        w_sar_word;
    logic [7:0]        w_sar_mask;
    logic [7:0]        w_sar_kept;
    logic [7:0]        w_sar_next;
    logic              w_restart;

    // Two-flop synchronizer on the Gray phase, plus previous binary sample
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            r_ph_s1       <= '0;
            r_ph_s2       <= '0;
            r_ph_bin_prev <= '0;
        end else begin
            r_ph_s1       <= i_dco_phase_gray;
            r_ph_s2       <= r_ph_s1;
            r_ph_bin_prev <= w_ph_bin;
        end
    end

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        w_ph_bin = '0;
        for (int i = 0; i < PH_W; i++) begin
            w_ph_bin[i] = ^(r_ph_s2 >> i);
        end
    end

    // Per-cycle phase delta and saturating accumulate
    always_comb begin
        w_delta    = w_ph_bin - r_ph_bin_prev;
        w_acc_sum  = {1'b0, r_acc} + (MEAS_W+1)'(w_delta);
        w_acc_next = w_acc_sum[MEAS_W] ? '1 : w_acc_sum[MEAS_W-1:0];
    end

    // Step phase decode, tolerance check and SAR next-word computation
    always_comb begin
        w_measuring = (r_state == c_ST_COARSE) || (r_state == c_ST_FINE) ||
                      (r_state == c_ST_VERIFY) || (r_state == c_ST_LOCK);
        w_in_win    = w_measuring && (r_cnt >= c_WIN_START) && (r_cnt < c_DECIDE);
        w_decide    = w_measuring && (r_cnt == c_DECIDE);
        w_diff      = (r_acc >= i_fcw) ? (r_acc - i_fcw) : (i_fcw - r_acc);
        w_in_tol    = (w_diff <= c_TOL);
        // Larger word means slower DCO: keep the trial bit while still too fast
        w_sar_word  = (r_state == c_ST_COARSE) ? r_ctw : r_ftw;
        w_sar_mask  = 8'd1 << r_bit;
        w_sar_kept  = (r_acc >= i_fcw) ? w_sar_word : (w_sar_word & ~w_sar_mask);
        w_sar_next  = (r_bit != 3'd0) ? (w_sar_kept | (w_sar_mask >> 1)) : w_sar_kept;
        w_restart   = (i_start && ((r_state == c_ST_IDLE) || (r_state == c_ST_LOCK) ||
                                   (r_state == c_ST_FAIL))) ||
                      ((r_state == c_ST_LOCK) && w_decide && !w_in_tol);
    end

    // Step timing, measurement and search state machine
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_acc        <= '0;
            r_meas       <= '0;
            r_meas_valid <= 1'b0;
            r_ctw        <= '0;
            r_ftw        <= '0;
            r_dco_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_lock       <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if (w_measuring) begin
                r_cnt <= w_decide ? '0 : r_cnt + 1'b1;
            end
            if (w_in_win) begin
                r_acc <= w_acc_next;
            end else if (w_decide) begin
                r_acc        <= '0;
                r_meas       <= r_acc;
                r_meas_valid <= 1'b1;
            end

            case (r_state)
                c_ST_COARSE: begin
                    if (w_decide) begin
                        r_ctw <= w_sar_next;
                        if (r_bit == 3'd0) begin
                            r_ftw   <= 8'h80;
                            r_bit   <= 3'd7;
                            r_state <= c_ST_FINE;
                        end else begin
                            r_bit <= r_bit - 1'b1;
                        end
                    end
                end
                c_ST_FINE: begin
                    if (w_decide) begin
                        r_ftw <= w_sar_next;
                        if (r_bit == 3'd0) begin
                            r_state <= c_ST_VERIFY;
                        end else begin
                            r_bit <= r_bit - 1'b1;
                        end
                    end
                end
                c_ST_VERIFY: begin
                    if (w_decide) begin
                        r_busy <= 1'b0;
                        if (w_in_tol) begin
                            r_lock  <= 1'b1;
                            r_state <= c_ST_LOCK;
                        end else begin
                            r_fail  <= 1'b1;
                            r_state <= c_ST_FAIL;
                        end
                    end
                end
                c_ST_LOCK: begin
`ifdef DCO_TUNE_TRACK_EN
                    // Fine tracking; lock loss (restart below) overrides it
                    if (w_decide && w_in_tol) begin
                        if ((r_acc > i_fcw) && (r_ftw != 8'hFF)) begin
                            r_ftw <= r_ftw + 1'b1;
                        end else if ((r_acc < i_fcw) && (r_ftw != 8'h00)) begin
                            r_ftw <= r_ftw - 1'b1;
                        end
                    end
`else
                    // Words stay static; only lock-loss detection (restart below)
                    r_ftw <= r_ftw;
`endif
                end
                default: begin
                    // IDLE and FAIL wait for start, handled by restart below
                end
            endcase

            if (w_restart) begin
                r_state  <= c_ST_COARSE;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_bit    <= c_CTW_TOP;
                r_ctw    <= c_CTW_INIT;
                r_ftw    <= 8'h00;
                r_dco_en <= 1'b1;
                r_busy   <= 1'b1;
                r_lock   <= 1'b0;
                r_fail   <= 1'b0;
            end
        end
    end

    assign o_ctw        = r_ctw;
    assign o_ftw        = r_ftw;
    assign o_dco_en     = r_dco_en;
    assign o_busy       = r_busy;
    assign o_lock       = r_lock;
    assign o_fail       = r_fail;
    assign o_meas       = r_meas;
    assign o_meas_valid = r_meas_valid;

endmodule
`default_nettype wire

// File: tb/tb_dco_tune_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dco_tune_ctrl
// Description : Directed self-checking bench for dco_tune_ctrl with a DCO
//               model producing (1000 + offset - 40*ctw - ftw) cycles per
//               64-cycle window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dco_tune_ctrl;

    logic        clk_ref;
    logic        rst;
    logic        i_start;
    logic [15:0] i_fcw;
    logic [7:0]  i_dco_phase_gray;
    logic [7:0]  o_ctw;
    logic [7:0]  o_ftw;
    logic        o_dco_en;
    logic        o_busy;
    logic        o_lock;
    logic        o_fail;
    logic [15:0] o_meas;
    logic        o_meas_valid;

    int n_checks;
    int n_errors;
    int cyc;
    int mv_cnt;
    int offset;
    int s_cyc;

    dco_tune_ctrl u_dut (
        .clk_ref          (clk_ref),
        .rst              (rst),
        .i_start          (i_start),
        .i_fcw            (i_fcw),
        .i_dco_phase_gray (i_dco_phase_gray),
        .o_ctw            (o_ctw),
        .o_ftw            (o_ftw),
        .o_dco_en         (o_dco_en),
        .o_busy           (o_busy),
        .o_lock           (o_lock),
        .o_fail           (o_fail),
        .o_meas           (o_meas),
        .o_meas_valid     (o_meas_valid)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    // DCO model: fractional phase accumulator so any 64 consecutive cycles
    // at a constant rate advance the phase by exactly the rate
    initial begin
        int frac;
        int n;
        logic [7:0] ph_bin;
        frac             = 0;
        ph_bin           = 8'd0;
        i_dco_phase_gray = 8'd0;
        forever begin
            @(negedge clk_ref);
            if (o_dco_en)
                n = 1000 + offset - 40 * int'(o_ctw) - int'(o_ftw);
            else
                n = 0;
            frac   = frac + n;
            ph_bin = ph_bin + 8'(frac / 64);
            frac   = frac % 64;
            i_dco_phase_gray = ph_bin ^ (ph_bin >> 1);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_ref);
        #1;
        cyc++;
        if (o_meas_valid) mv_cnt++;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_start();
        @(negedge clk_ref);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        s_cyc  = cyc;
        mv_cnt = 0;
    endtask

    task automatic wait_meas_valid(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!o_meas_valid && k < 200);
        check_val(tag, 32'(o_meas_valid), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!(o_lock || o_fail) && k < budget) begin
            tick();
            k++;
        end
        check_val(tag, 32'(o_lock || o_fail), 32'd1);
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        mv_cnt   = 0;
        offset   = 0;
        s_cyc    = 0;
        rst      = 1'b1;
        i_start  = 1'b0;
        i_fcw    = 16'd700;

        // Reset values
        repeat (3) tick();
        check_val("rst_ctw",   32'(o_ctw), 32'd0);
        check_val("rst_ftw",   32'(o_ftw), 32'd0);
        check_val("rst_flags", 32'({o_dco_en, o_busy, o_lock, o_fail, o_meas_valid}), 32'd0);
        check_val("rst_meas",  32'(o_meas), 32'd0);
        @(negedge clk_ref);
        rst = 1'b0;
        repeat (3) tick();

        // Normal lock at 700
        do_start();
        check_val("busy_rise", 32'(o_busy), 32'd1);
        check_val("en_rise",   32'(o_dco_en), 32'd1);
        check_val("ctw_init",  32'(o_ctw), 32'd8);
        wait_until(s_cyc + 948);
        check_val("lock_early", 32'(o_lock), 32'd0);
        check_val("busy_early", 32'(o_busy), 32'd1);
        wait_until(s_cyc + 949);
        check_val("lock_n",   32'(o_lock), 32'd1);
        check_val("busy_n",   32'(o_busy), 32'd0);
        check_val("fail_n",   32'(o_fail), 32'd0);
        check_val("ctw_n",    32'(o_ctw), 32'd7);
        check_val("ftw_n",    32'(o_ftw), 32'd20);
        check_val("meas_n",   32'(o_meas), 32'd700);
        check_val("mv_count", 32'(mv_cnt), 32'd13);

        // Start in LOCK restarts; start while busy is ignored
        do_start();
        check_val("relock_drop", 32'(o_lock), 32'd0);
        check_val("relock_busy", 32'(o_busy), 32'd1);
        check_val("relock_ctw",  32'(o_ctw), 32'd8);
        wait_until(s_cyc + 299);
        k = s_cyc;
        do_start();
        s_cyc = k;
        wait_until(s_cyc + 948);
        check_val("filt_early", 32'(o_lock), 32'd0);
        wait_until(s_cyc + 949);
        check_val("filt_lock", 32'(o_lock), 32'd1);
        check_val("filt_ftw",  32'(o_ftw), 32'd20);

        // Lock loss: DCO shifts by +50 right after a decide cycle
        wait_meas_valid("mv_before_shift");
        offset = 50;
        k = 0;
        while (o_lock && k < 80) begin
            tick();
            k++;
        end
        check_val("loss_lock", 32'(o_lock), 32'd0);
        check_val("loss_busy", 32'(o_busy), 32'd1);
        wait_done("reacq_done", 1000);
        check_val("reacq_lock", 32'(o_lock), 32'd1);
        check_val("reacq_ctw",  32'(o_ctw), 32'd8);
        check_val("reacq_ftw",  32'(o_ftw), 32'd30);
        check_val("reacq_meas", 32'(o_meas), 32'd700);

        // One-LSB drift in LOCK: tracked in the track build, held otherwise
        wait_meas_valid("mv_before_drift");
        offset = 51;
        wait_meas_valid("mv_after_drift");
        check_val("drift_meas", 32'(o_meas), 32'd701);
        check_val("drift_lock", 32'(o_lock), 32'd1);
`ifdef DCO_TUNE_TRACK_EN
        check_val("drift_ftw",  32'(o_ftw), 32'd31);
`else
        check_val("drift_ftw",  32'(o_ftw), 32'd30);
`endif

        // Unreachable target
        offset = 0;
        @(negedge clk_ref);
        i_fcw = 16'd1100;
        do_start();
        wait_until(s_cyc + 948);
        check_val("unr_early", 32'(o_fail), 32'd0);
        wait_until(s_cyc + 949);
        check_val("unr_fail", 32'(o_fail), 32'd1);
        check_val("unr_lock", 32'(o_lock), 32'd0);
        check_val("unr_busy", 32'(o_busy), 32'd0);
        check_val("unr_ctw",  32'(o_ctw), 32'd0);
        check_val("unr_ftw",  32'(o_ftw), 32'd0);
        check_val("unr_meas", 32'(o_meas), 32'd1000);
        check_val("unr_en",   32'(o_dco_en), 32'd1);
        repeat (100) tick();
        check_val("unr_hold", 32'(o_fail), 32'd1);

        // Reset during FINE, then reacquire
        i_fcw = 16'd700;
        do_start();
        check_val("fail_clear", 32'(o_fail), 32'd0);
        wait_until(s_cyc + 400);
        rst = 1'b1;
        #1;
        check_val("mid_ctw",   32'(o_ctw), 32'd0);
        check_val("mid_ftw",   32'(o_ftw), 32'd0);
        check_val("mid_flags", 32'({o_dco_en, o_busy, o_lock, o_fail, o_meas_valid}), 32'd0);
        check_val("mid_meas",  32'(o_meas), 32'd0);
        repeat (2) tick();
        @(negedge clk_ref);
        rst = 1'b0;
        repeat (2) tick();
        do_start();
        wait_until(s_cyc + 949);
        check_val("post_lock", 32'(o_lock), 32'd1);
        check_val("post_ctw",  32'(o_ctw), 32'd7);
        check_val("post_ftw",  32'(o_ftw), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dco_tune_ctrl.md
# dco_tune_ctrl

Closed-loop tuning controller that drives the DCO's coarse and fine tuning words (`ctw`, `ftw`) and its `enable`. It reads back a Gray-coded DCO cycle counter, measures DCO cycles per reference window, and binary-searches CTW and then FTW until the measured count matches the target frequency control word `fcw`. In the ADPLL it sits between the frequency command and the DCO, and provides the acquisition/lock front end ahead of phase tracking.

## Interface
- `CTW_BITS`, 4: searched CTW bits (CTW above 15 saturates in the DCO); upper CTW bits are driven 0.
- `PH_W`, 8: width of the Gray DCO phase counter.
- `MEAS_W`, 16: measurement and `fcw` width.
- `SETTLE`, 8: discarded cycles after each word change (covers the 2-flop sync).
- `WIN`, 64: accumulation cycles per measurement.
- `LOCK_TOL`, 2: allowed |meas − fcw| in the lock and verify checks.
- `clk_ref` input 1: reference clock; the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle pulse that begins acquisition.
- `fcw` input MEAS_W: target DCO cycles per WIN window.
- `dco_phase_gray` input PH_W: free-running Gray-coded DCO cycle count, asynchronous to `clk_ref`.
- `ctw` output 8: coarse tuning word.
- `ftw` output 8: fine tuning word.
- `dco_en` output 1: DCO enable.
- `busy` output 1: search or verify in progress.
- `lock` output 1: locked.
- `fail` output 1: verify failed.
- `meas` output MEAS_W: last completed measurement.
- `meas_valid` output 1: one-cycle pulse when `meas` updates.

## Operation
- **Phase input path:** 2-flop synchronizer, then Gray-to-binary. `delta = bin − bin_prev` (mod 2^PH_W) is computed every cycle.
- **Accumulation:** `delta` is accumulated only during window cycles, and the accumulator saturates at 2^MEAS_W−1.
- **Step structure:** every step is SETTLE settle cycles, then WIN window cycles, then 1 decide cycle. The decide cycle updates `meas` and pulses `meas_valid`.
- **States:** IDLE, COARSE, FINE, VERIFY, LOCK, FAIL.
- **IDLE:** on `start`, assert `dco_en`, clear `ftw`, set `ctw` = only bit CTW_BITS−1 set, go to COARSE.
- **COARSE decide (SAR rule):** larger word means a slower DCO.
  - If meas ≥ fcw, keep the trial bit; otherwise clear it.
  - Then set the next lower bit.
  - After bit 0, set `ftw` = 0x80 and go to FINE.
- **FINE:** same SAR rule on `ftw` bits 7..0. After bit 0, go to VERIFY with the final words.
- **VERIFY:** one step at the final words.
  - If |meas − fcw| ≤ LOCK_TOL, go to LOCK.
  - Otherwise go to FAIL.
- **LOCK:** `lock`=1, `busy`=0. Measures continuously.
  - If any window gives |meas − fcw| > LOCK_TOL, drop `lock` in the decide cycle and restart COARSE, as on `start`.
- **FAIL:** `fail`=1, `busy`=0, words held, `dco_en` held 1. Leaves only on `start`.
- **`start` handling:** ignored while `busy`=1. In LOCK or FAIL it restarts the search and clears `lock`/`fail`.
- **`fcw` sampling:** `fcw` is sampled in each decide cycle; a change takes effect at the next decision.
- **Reset values:** `ctw`=0, `ftw`=0, `dco_en`=0, `busy`=0, `lock`=0, `fail`=0, `meas`=0, `meas_valid`=0; state IDLE. Reset mid-search aborts immediately to these values.

## Timing
- Step length T = SETTLE + WIN + 1 = 73 cycles at the defaults.
- `busy` rises the cycle after `start`.
- `lock`/`fail` assert T·(CTW_BITS+8+1) = 949 cycles after `start` (defaults).
- Words change only on the cycle after a decide cycle, and settle begins on that cycle.
- `meas_valid` fires exactly once per step.
- DCO cycles per `clk_ref` cycle must stay below 2^PH_W; otherwise the delta aliases.

## Configuration
- **`DCO_TUNE_TRACK_EN` defined:** in LOCK, each decide cycle nudges `ftw`:
  - meas > fcw: `ftw`+1, saturating at 255.
  - meas < fcw: `ftw`−1, saturating at 0.
  - Equal: hold.
  - The lock-loss check takes priority over the nudge.
- **Not defined:** LOCK holds the words static and performs only lock-loss detection.

## Test plan
All scenarios use defaults and a bench DCO model where count per window = 1000 − 40·ctw − ftw.
- **Normal lock:** `fcw`=700, pulse `start` → `ctw`=7, `ftw`=20, `meas`=700, `lock`=1 at cycle 949, `busy`=0.
- **Unreachable target:** `fcw`=1100 → `ctw`=0, `ftw`=0, `meas`=1000, `fail`=1, `lock`=0 at cycle 949.
- **Reset mid-search:** assert `rst` during FINE → all outputs at reset values in the same cycle. A new `start` reacquires `ctw`=7, `ftw`=20.
- **Lock loss:** after lock at 700, shift the model by +50 → `lock`=0 within 73 cycles, `busy`=1, reacquire with `ctw`=8, `ftw`=30, `lock`=1.
- **Start filtering:** `start` pulse while `busy` → ignored, and completion still at cycle 949. `start` in LOCK → `lock`=0, search restarts.
- **Tracking (`DCO_TUNE_TRACK_EN`):** locked at 700, shift the model by +1 → `ftw` 20→21 after the next decide, and `lock` stays 1.
